// File: rtl/fetch_if.sv
// fetch_if: imem read handshake, EX redirect, ID stall and IF/ID outputs of the fetch stage
interface fetch_if;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  modport master (
    output imem_address, imem_read, id_valid, id_pc, id_instr,
           id_opcode, id_funct3, id_funct7, id_rs1, id_rs2, id_rd,
    input  imem_rdata, imem_resp, stall, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_address, imem_read, id_valid, id_pc, id_instr,
           id_opcode, id_funct3, id_funct7, id_rs1, id_rs2, id_rd,
    output imem_rdata, imem_resp, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with PC, imem handshake, one-entry skid buffer and IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000060
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t      state;
  logic [31:0] pc_reg, drop_addr, buf_pc, buf_instr, id_pc, id_instr;
  logic        buf_valid, id_valid;
  logic        accept, hold, buf_next;
  assign accept   = state == REQ && bus.imem_resp && !bus.redirect_valid;
  assign hold     = id_valid && bus.stall;
  assign buf_next = !bus.redirect_valid && (hold ? buf_valid || accept : buf_valid && accept);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc_reg    <= RESET_PC;
      drop_addr <= RESET_PC;
      buf_valid <= 1'b0;
      buf_pc    <= 32'h0;
      buf_instr <= 32'h00000013;
      id_valid  <= 1'b0;
      id_pc     <= 32'h0;
      id_instr  <= 32'h00000013;
    end else begin
      buf_valid <= buf_next;
      if (accept && (hold || buf_valid)) begin
        buf_pc    <= pc_reg;
        buf_instr <= bus.imem_rdata;
      end
      if (bus.redirect_valid)
        id_valid <= 1'b0;
      else if (!hold) begin
        id_valid <= buf_valid || accept;
        if (buf_valid) begin
          id_pc    <= buf_pc;
          id_instr <= buf_instr;
        end else if (accept) begin
          id_pc    <= pc_reg;
          id_instr <= bus.imem_rdata;
        end
      end
      if (bus.redirect_valid)
        pc_reg <= bus.redirect_pc;
      else if (accept)
        pc_reg <= pc_reg + 32'd4;
      // DROP keeps the address of the abandoned request stable until memory answers
      unique case (state)
        IDLE: if (bus.redirect_valid || !buf_next) state <= REQ;
        REQ: begin
          drop_addr <= pc_reg;
          if (bus.redirect_valid && !bus.imem_resp)
            state <= DROP;
          else if (accept && buf_next)
            state <= IDLE;
        end
        DROP: if (bus.imem_resp) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.imem_read    = state != IDLE;
  assign bus.imem_address = state == DROP ? drop_addr : pc_reg;
  assign bus.id_valid     = id_valid;
  assign bus.id_pc        = id_pc;
  assign bus.id_instr     = id_instr;
  assign bus.id_opcode    = id_instr[6:0];
  assign bus.id_funct3    = id_instr[14:12];
  assign bus.id_funct7    = id_instr[31:25];
  assign bus.id_rs1       = id_instr[19:15];
  assign bus.id_rs2       = id_instr[24:20];
  assign bus.id_rd        = id_instr[11:7];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, reset corner case and randomized stream scoreboard for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] BAD = 32'hDEADBEEF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  fetch_if bus();
  fetch_stage #(.RESET_PC(32'h00000060)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] stall, rv, rpc, resp, rdata;
    logic [31:0] read, addr, idv, ipc;
  } vec_t;
  vec_t vt[32];
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc,
                       input logic resp, input logic [31:0] rdata);
    bus.stall          = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_resp      = resp;
    bus.imem_rdata     = rdata;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic        busy, prev_rv, s, rv, resp;
    logic [31:0] req_addr, exp_pc, rpc, w;
    int          age, lat, consumed;
    // stall rv rpc resp rdata | read addr id_valid id_pc
    vt[0]  = '{0, 0, 0, 0, 0,           0, 'h60, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 0,           1, 'h60, 0, 0};
    vt[2]  = '{0, 0, 0, 1, NOP,         1, 'h60, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 0,           1, 'h64, 1, 'h60};
    vt[4]  = '{0, 0, 0, 1, NOP,         1, 'h64, 0, 0};
    vt[5]  = '{1, 0, 0, 0, 0,           1, 'h68, 1, 'h64};
    vt[6]  = '{1, 0, 0, 1, NOP,         1, 'h68, 1, 'h64};
    vt[7]  = '{1, 0, 0, 0, 0,           0, 'h6C, 1, 'h64};
    vt[8]  = '{1, 0, 0, 0, 0,           0, 'h6C, 1, 'h64};
    vt[9]  = '{0, 0, 0, 0, 0,           0, 'h6C, 1, 'h64};
    vt[10] = '{0, 0, 0, 0, 0,           1, 'h6C, 1, 'h68};
    vt[11] = '{0, 0, 0, 1, NOP,         1, 'h6C, 0, 0};
    vt[12] = '{0, 0, 0, 0, 0,           1, 'h70, 1, 'h6C};
    vt[13] = '{0, 1, 'h200, 0, 0,       1, 'h70, 0, 0};
    vt[14] = '{0, 0, 0, 0, 0,           1, 'h70, 0, 0};
    vt[15] = '{0, 0, 0, 1, BAD,         1, 'h70, 0, 0};
    vt[16] = '{0, 0, 0, 0, 0,           1, 'h200, 0, 0};
    vt[17] = '{0, 0, 0, 1, NOP,         1, 'h200, 0, 0};
    vt[18] = '{0, 0, 0, 0, 0,           1, 'h204, 1, 'h200};
    vt[19] = '{0, 1, 'h300, 1, BAD,     1, 'h204, 0, 0};
    vt[20] = '{0, 0, 0, 0, 0,           1, 'h300, 0, 0};
    vt[21] = '{0, 0, 0, 1, NOP,         1, 'h300, 0, 0};
    vt[22] = '{1, 0, 0, 0, 0,           1, 'h304, 1, 'h300};
    vt[23] = '{1, 0, 0, 1, NOP,         1, 'h304, 1, 'h300};
    vt[24] = '{1, 1, 'h400, 0, 0,       0, 'h308, 1, 'h300};
    vt[25] = '{0, 0, 0, 0, 0,           1, 'h400, 0, 0};
    vt[26] = '{1, 0, 0, 1, NOP,         1, 'h400, 0, 0};
    vt[27] = '{0, 1, 32'hFFFF_FFFC, 0, 0, 1, 'h404, 1, 'h400};
    vt[28] = '{0, 0, 0, 1, BAD,         1, 'h404, 0, 0};
    vt[29] = '{0, 0, 0, 0, 0,           1, 32'hFFFF_FFFC, 0, 0};
    vt[30] = '{0, 0, 0, 1, NOP,         1, 32'hFFFF_FFFC, 0, 0};
    vt[31] = '{0, 0, 0, 0, 0,           1, 0, 1, 32'hFFFF_FFFC};
    drive(0, 0, 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(vt[i].stall[0], vt[i].rv[0], vt[i].rpc, vt[i].resp[0], vt[i].rdata);
      chk($sformatf("vec%0d imem_read", i), 32'(bus.imem_read), vt[i].read);
      chk($sformatf("vec%0d imem_address", i), bus.imem_address, vt[i].addr);
      chk($sformatf("vec%0d id_valid", i), 32'(bus.id_valid), vt[i].idv);
      if (vt[i].idv[0]) begin
        chk($sformatf("vec%0d id_pc", i), bus.id_pc, vt[i].ipc);
        chk($sformatf("vec%0d id_instr", i), bus.id_instr, NOP);
        chk($sformatf("vec%0d id_opcode", i), 32'(bus.id_opcode), 32'h13);
      end
      tick;
    end
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst imem_read", 32'(bus.imem_read), 0);
    chk("rst imem_address", bus.imem_address, 32'h60);
    chk("rst id_valid", 32'(bus.id_valid), 0);
    chk("rst id_pc", bus.id_pc, 0);
    chk("rst id_instr", bus.id_instr, NOP);
    tick;
    rst = 1'b0;
    drive(0, 0, 0, 1, BAD);
    chk("stray imem_read", 32'(bus.imem_read), 0);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("post-rst imem_read", 32'(bus.imem_read), 1);
    chk("post-rst imem_address", bus.imem_address, 32'h60);
    chk("post-rst id_valid", 32'(bus.id_valid), 0);
    tick;
    drive(0, 0, 0, 1, NOP);
    chk("post-rst id_valid held", 32'(bus.id_valid), 0);
    tick;
    drive(0, 0, 0, 0, 0);
    chk("post-rst first id_valid", 32'(bus.id_valid), 1);
    chk("post-rst first id_pc", bus.id_pc, 32'h60);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    // random phase: the delivered stream must be consecutive PCs from the latest target
    busy = 1'b0;
    prev_rv = 1'b0;
    exp_pc = 32'h60;
    age = 0;
    lat = 1;
    consumed = 0;
    req_addr = 0;
    for (int c = 0; c < 4000; c++) begin
      if (prev_rv) chk("rand id_valid after redirect", 32'(bus.id_valid), 0);
      resp = 1'b0;
      if (busy) begin
        chk("rand read held", 32'(bus.imem_read), 1);
        chk("rand addr stable", bus.imem_address, req_addr);
        age++;
      end else if (bus.imem_read) begin
        busy = 1'b1;
        age = 0;
        req_addr = bus.imem_address;
        lat = $urandom_range(1, 3);
      end
      if (busy && age == lat) begin
        resp = 1'b1;
        busy = 1'b0;
      end
      s = $urandom_range(0, 9) < 3;
      rv = $urandom_range(0, 15) == 0;
      rpc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      if (bus.id_valid && !s && !rv) begin
        w = word(exp_pc);
        chk("rand id_pc", bus.id_pc, exp_pc);
        chk("rand id_instr", bus.id_instr, w);
        chk("rand id_opcode", 32'(bus.id_opcode), 32'(w[6:0]));
        chk("rand id_funct3", 32'(bus.id_funct3), 32'(w[14:12]));
        chk("rand id_funct7", 32'(bus.id_funct7), 32'(w[31:25]));
        chk("rand id_rs1", 32'(bus.id_rs1), 32'(w[19:15]));
        chk("rand id_rs2", 32'(bus.id_rs2), 32'(w[24:20]));
        chk("rand id_rd", 32'(bus.id_rd), 32'(w[11:7]));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (rv) exp_pc = rpc;
      prev_rv = rv;
      drive(s, rv, rpc, resp, resp ? word(req_addr) : BAD);
      tick;
    end
    chk("rand progress", 32'(consumed >= 400), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
